// File: rtl/crc_engine.sv
// Parallel CRC generator/checker: DATA_W bits per beat, any polynomial/init/reflection/xor-out,
// registered result with its own valid/ready handshake and a residue-match flag.
module crc_engine #(
    parameter int          CRC_W       = 32,
    parameter int          DATA_W      = 8,
    parameter logic [31:0] POLY        = 32'h04C11DB7,
    parameter logic [31:0] INIT        = 32'hFFFFFFFF,
    parameter bit          REFLECT_IN  = 1'b1,
    parameter bit          REFLECT_OUT = 1'b1,
    parameter logic [31:0] XOR_OUT     = 32'hFFFFFFFF,
    parameter logic [31:0] CHECK       = 32'h2144DF1C
) (
    input  logic              clk,
    input  logic              res,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              data_last,
    output logic              data_ready,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_valid,
    input  logic              crc_ready,
    output logic              crc_match
);
    localparam logic [CRC_W-1:0] POLY_W  = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] INIT_W  = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOR_W   = XOR_OUT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] CHECK_W = CHECK[CRC_W-1:0];

    typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [CRC_W-1:0] crc_reg, crc_nxt, crc_fin;
    logic             beat_xfer, res_xfer;

    // DATA_W-fold unrolled LFSR step; bit order within the beat follows REFLECT_IN.
    always_comb begin
        logic [CRC_W-1:0] c;
        logic             bit_in;
        logic             fb;
        c      = crc_reg;
        bit_in = 1'b0;
        fb     = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            bit_in = REFLECT_IN ? data_in[i] : data_in[DATA_W-1-i];
            fb     = c[CRC_W-1] ^ bit_in;
            c      = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY_W : '0);
        end
        crc_nxt = c;
    end

    always_comb begin
        crc_fin = crc_nxt;
        if (REFLECT_OUT) begin
            for (int k = 0; k < CRC_W; k++) crc_fin[k] = crc_nxt[CRC_W-1-k];
        end
        crc_fin = crc_fin ^ XOR_W;
    end

    // Handshakes: a beat moves when data_valid && data_ready, a result moves when
    // crc_valid && crc_ready; neither side may make valid depend on its ready.
    always_ff @(posedge clk) begin
        if (res) state <= ACCUM;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        data_ready = (state == ACCUM);
        beat_xfer  = data_valid && data_ready;
        res_xfer   = crc_valid && crc_ready;
        case (state)
            ACCUM:   if (beat_xfer && data_last) state_nxt = DONE;
            DONE:    if (res_xfer)               state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            crc_reg   <= INIT_W;
            crc_out   <= '0;
            crc_match <= 1'b0;
            crc_valid <= 1'b0;
        end else begin
            if (beat_xfer) begin
                if (data_last) begin
                    crc_out   <= crc_fin;
                    crc_match <= (crc_fin == CHECK_W);
                    crc_valid <= 1'b1;
                    crc_reg   <= INIT_W;
                end else begin
                    crc_reg <= crc_nxt;
                end
            end
            if (state == DONE && res_xfer) crc_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_crc_engine.sv
// Bench for crc_engine: three configurations (CRC-32 byte-wide, CRC-16/CCITT, CRC-32 serial)
// checked against a polynomial long-division reference through a tagged expected queue.
module tb_crc_engine;
    localparam int          CW [3] = '{32, 16, 32};
    localparam int          DW [3] = '{8, 8, 1};
    localparam logic [31:0] PL [3] = '{32'h04C11DB7, 32'h00001021, 32'h04C11DB7};
    localparam logic [31:0] IV [3] = '{32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFFF};
    localparam bit          RI [3] = '{1'b1, 1'b0, 1'b1};
    localparam bit          RO [3] = '{1'b1, 1'b0, 1'b1};
    localparam logic [31:0] XO [3] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    localparam logic [31:0] CK [3] = '{32'h2144DF1C, 32'h00000000, 32'h2144DF1C};
    localparam int W = 35;

    typedef logic [7:0] byte_q_t[$];

    logic        clk;
    logic        res;
    logic [7:0]  din    [3];
    logic        dvalid [3];
    logic        dlast  [3];
    logic        cready [3];
    logic        dready [3];
    logic        cvalid [3];
    logic        cmatch [3];
    logic [31:0] cout   [3];

    logic [W-1:0] exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    bit  rand_mode = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [CW[g]-1:0] co;
        logic dr, cv, cm;
        crc_engine #(
            .CRC_W(CW[g]), .DATA_W(DW[g]), .POLY(PL[g]), .INIT(IV[g]),
            .REFLECT_IN(RI[g]), .REFLECT_OUT(RO[g]), .XOR_OUT(XO[g]), .CHECK(CK[g])
        ) u_dut (
            .clk(clk), .res(res),
            .data_in(din[g][DW[g]-1:0]), .data_valid(dvalid[g]), .data_last(dlast[g]),
            .data_ready(dr), .crc_out(co), .crc_valid(cv), .crc_ready(cready[g]),
            .crc_match(cm)
        );
        assign dready[g] = dr;
        assign cvalid[g] = cv;
        assign cmatch[g] = cm;
        assign cout[g]   = 32'(co);
    end

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mask_of(input int g);
        return (CW[g] == 32) ? 32'hFFFFFFFF : ((32'h1 << CW[g]) - 32'h1);
    endfunction

    // Reference: remainder of (message with init folded into its head) * x^W over the polynomial.
    function automatic logic [31:0] model(input int g, input byte_q_t q);
        bit s[$];
        int w = CW[g];
        int n;
        logic [31:0] r  = '0;
        logic [31:0] rr = '0;
        logic [31:0] pv = PL[g];
        logic [31:0] iv = IV[g];
        foreach (q[i])
            for (int b = 0; b < 8; b++) s.push_back(RI[g] ? q[i][b] : q[i][7-b]);
        n = s.size();
        for (int i = 0; i < w; i++) s.push_back(1'b0);
        for (int i = 0; i < w; i++) s[i] = s[i] ^ iv[w-1-i];
        for (int i = 0; i < n; i++)
            if (s[i]) begin
                s[i] = 1'b0;
                for (int j = 1; j <= w; j++) s[i+j] = s[i+j] ^ pv[w-j];
            end
        for (int k = 0; k < w; k++) r[w-1-k] = s[n+k];
        if (RO[g]) begin
            for (int k = 0; k < w; k++) rr[k] = r[w-1-k];
        end else begin
            rr = r;
        end
        return (rr ^ XO[g]) & mask_of(g);
    endfunction

    task automatic push_exp(input int g, input logic [31:0] c);
        logic m;
        m = (c == (CK[g] & mask_of(g)));
        exp_q.push_back({2'(g), m, c});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic wait_xfer(input int g);
        int  t = 0;
        bit  acc = 1'b0;
        do begin
            @(negedge clk);
            acc = dready[g];
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 200);
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL xfer_timeout dut%0d: got no data_ready, required a transfer", g);
        end
    endtask

    task automatic send_frame(input int g, input byte_q_t q, input bit with_last);
        int nb = (DW[g] == 1) ? 8 : 1;
        for (int i = 0; i < q.size(); i++)
            for (int b = 0; b < nb; b++) begin
                din[g]    = (DW[g] == 1) ? {7'b0, q[i][b]} : q[i];
                dvalid[g] = 1'b1;
                dlast[g]  = with_last && (i == q.size() - 1) && (b == nb - 1);
                wait_xfer(g);
                dvalid[g] = 1'b0;
                dlast[g]  = 1'b0;
                din[g]    = 8'($urandom_range(0, 255));
                if (rand_mode && $urandom_range(0, 3) == 0)
                    repeat ($urandom_range(1, 2)) begin
                        dlast[g] = 1'($urandom_range(0, 1));
                        @(posedge clk);
                        #1;
                        dlast[g] = 1'b0;
                    end
            end
    endtask

    // random result backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode)
                for (int g = 0; g < 3; g++) cready[g] = 1'($urandom_range(0, 1));
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!res)
            for (int g = 0; g < 3; g++)
                if (cvalid[g] && cready[g]) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_result dut%0d: got %h, required no result", g, cout[g]);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(e[34:33]) != g || e[31:0] !== cout[g] || e[32] !== cmatch[g]) begin
                            n_err++;
                            $display("FAIL result dut%0d: got crc=%h match=%b, required dut%0d crc=%h match=%b",
                                     g, cout[g], cmatch[g], e[34:33], e[31:0], e[32]);
                        end
                    end
                end
    end

    initial begin
        byte_q_t s9, q, f1;
        logic [31:0] c;
        int t;
        res = 1'b1;
        for (int g = 0; g < 3; g++) begin
            din[g] = '0; dvalid[g] = 1'b0; dlast[g] = 1'b0; cready[g] = 1'b1;
        end
        for (int i = 0; i < 9; i++) s9.push_back(8'(8'h31 + i));
        repeat (3) @(posedge clk);
        #1 res = 1'b0;

        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("rst_data_ready", 32'(dready[g]), 32'd1);
            chk("rst_crc_valid", 32'(cvalid[g]), 32'd0);
            chk("rst_crc_out", cout[g], 32'd0);
            chk("rst_crc_match", 32'(cmatch[g]), 32'd0);
        end
        @(posedge clk);
        #1;

        // check string, latency and one-cycle valid
        push_exp(0, 32'hCBF43926);
        send_frame(0, s9, 1'b1);
        chk("latency_valid", 32'(cvalid[0]), 32'd1);
        @(posedge clk);
        #1;
        chk("valid_one_cycle", 32'(cvalid[0]), 32'd0);

        // frame with CRC appended gives the residue; one flipped bit breaks it
        q = s9;
        q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
        push_exp(0, 32'h2144DF1C);
        send_frame(0, q, 1'b1);
        q[2] = q[2] ^ 8'h04;
        push_exp(0, model(0, q));
        send_frame(0, q, 1'b1);

        push_exp(1, 32'h000029B1);
        send_frame(1, s9, 1'b1);
        push_exp(2, 32'hCBF43926);
        send_frame(2, s9, 1'b1);

        // result backpressure with a new frame waiting
        f1 = {};
        repeat (6) f1.push_back(8'($urandom_range(0, 255)));
        push_exp(0, model(0, f1));
        cready[0] = 1'b0;
        send_frame(0, f1, 1'b1);
        din[0] = s9[0]; dvalid[0] = 1'b1; dlast[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_data_ready", 32'(dready[0]), 32'd0);
            chk("bp_crc_valid", 32'(cvalid[0]), 32'd1);
            chk("bp_crc_hold", cout[0], model(0, f1));
        end
        @(posedge clk);
        #1 cready[0] = 1'b1;
        push_exp(0, 32'hCBF43926);
        send_frame(0, s9, 1'b1);

        // reset mid-frame discards it
        q = s9[0:3];
        send_frame(0, q, 1'b0);
        res = 1'b1;
        @(posedge clk);
        #1 res = 1'b0;
        push_exp(0, 32'hCBF43926);
        send_frame(0, s9, 1'b1);

        // randomized frames, gaps and backpressure
        rand_mode = 1'b1;
        for (int g = 0; g < 3; g++)
            for (int k = 0; k < 12; k++) begin
                q = {};
                repeat ($urandom_range((CW[g] == 16) ? 2 : 4, 10)) q.push_back(8'($urandom_range(0, 255)));
                if ($urandom_range(0, 3) == 0) begin
                    c = model(g, q);
                    if (CW[g] == 16) begin
                        q.push_back(c[15:8]); q.push_back(c[7:0]);
                    end else begin
                        q.push_back(c[7:0]); q.push_back(c[15:8]);
                        q.push_back(c[23:16]); q.push_back(c[31:24]);
                    end
                end
                push_exp(g, model(g, q));
                send_frame(g, q, 1'b1);
            end
        rand_mode = 1'b0;
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) cready[g] = 1'b1;

        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
